// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm controller.
// Optional feature macro: SNOOZE_EN adds the SNOOZE state.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_SET_TIME,
    ST_SET_ALARM,
    ST_RINGING
`ifdef SNOOZE_EN
    , ST_SNOOZE
`endif
  } state_t;

  localparam logic [3:0]  BCD_UNITS_MAX      = 4'd9;
  localparam logic [3:0]  MIN_TENS_MAX       = 4'd5;
  localparam logic [3:0]  HOUR_TENS_MAX      = 4'd2;
  localparam logic [3:0]  HOUR_UNITS_MAX_TOP = 4'd3;
  localparam logic [15:0] ALARM_RESET_BCD    = 16'h0600;

endpackage

// File: rtl/alarm_controller_if.sv
// Button, time and display/buzzer signals of the alarm controller.
// master drives the buttons and current time; slave is the controller.
interface alarm_controller_if;

  logic        tick;
  logic        set_clock;
  logic        set_alarm;
  logic        alarm_off;
  logic        inc_min;
  logic        inc_hour;
  logic [15:0] time_bcd;
  logic        load;
  logic [15:0] load_bcd;
  logic [15:0] alarm_bcd;
  logic        show_alarm;
  logic        run_enable;
  logic        alarm_out;

  modport master (
    output tick, set_clock, set_alarm, alarm_off, inc_min, inc_hour, time_bcd,
    input  load, load_bcd, alarm_bcd, show_alarm, run_enable, alarm_out
  );

  modport slave (
    input  tick, set_clock, set_alarm, alarm_off, inc_min, inc_hour, time_bcd,
    output load, load_bcd, alarm_bcd, show_alarm, run_enable, alarm_out
  );

endinterface

// File: rtl/alarm_controller_bcd_time_inc.sv
// Combinational BCD {h_t,h_u,m_t,m_u} minute/hour increment.
// Minutes wrap 59->00 without carrying into hours; hours wrap 23->00.
module Bcd_Time_Inc
  import alarm_pkg::*;
(
  input  logic [15:0] i_bcd,
  input  logic        i_inc_min,
  input  logic        i_inc_hour,
  output logic [15:0] o_bcd
);

  logic [3:0] w_ht, w_hu, w_mt, w_mu;

  always_comb begin
    w_ht = i_bcd[15:12];
    w_hu = i_bcd[11:8];
    w_mt = i_bcd[7:4];
    w_mu = i_bcd[3:0];
    if (i_inc_min) begin
      if (w_mu >= BCD_UNITS_MAX) begin
        w_mu = '0;
        w_mt = (w_mt >= MIN_TENS_MAX) ? '0 : w_mt + 4'd1;
      end else begin
        w_mu = w_mu + 4'd1;
      end
    end
    if (i_inc_hour) begin
      if (w_ht >= HOUR_TENS_MAX && w_hu >= HOUR_UNITS_MAX_TOP) begin
        w_ht = '0;
        w_hu = '0;
      end else if (w_hu >= BCD_UNITS_MAX) begin
        w_hu = '0;
        w_ht = w_ht + 4'd1;
      end else begin
        w_hu = w_hu + 4'd1;
      end
    end
    o_bcd = {w_ht, w_hu, w_mt, w_mu};
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: time/alarm setting FSM, alarm match and buzzer.
// Optional feature macro: SNOOZE_EN (inc_min while ringing snoozes).
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,
  parameter int unsigned SNOOZE_MINUTES = 5
) (
  input  logic              clk,
  input  logic              reset,
  alarm_controller_if.slave bus
);

  if (RING_SECONDS < 1 || RING_SECONDS > 255) begin : g_ring_range
    $error("RING_SECONDS must be in 1..255");
  end
  if (SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 9) begin : g_snooze_range
    $error("SNOOZE_MINUTES must be in 1..9");
  end

  localparam logic [7:0] RING_LAST = 8'(RING_SECONDS - 1);

  state_t      r_state, w_next;
  logic        r_prev_sc, r_prev_sa, r_prev_off, r_prev_im, r_prev_ih;
  logic        w_e_sc, w_e_sa, w_e_off, w_e_im, w_e_ih;
  logic [15:0] r_work, r_alarm, r_load_bcd;
  logic [15:0] w_work_inc, w_alarm_inc;
  logic        r_load, r_show, r_run_en, r_alarm_out, r_armed;
  logic [7:0]  r_ring_cnt;
  logic        w_match, w_ring_done, w_load_now, w_copy_work, w_trigger;

`ifdef SNOOZE_EN
  localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_MINUTES * 60 - 1);
  logic [9:0] r_snz_cnt;
  logic       w_snz_done;
  assign w_snz_done = (r_snz_cnt == SNOOZE_LAST);
`endif

  assign w_e_sc      = bus.set_clock & ~r_prev_sc;
  assign w_e_sa      = bus.set_alarm & ~r_prev_sa;
  assign w_e_off     = bus.alarm_off & ~r_prev_off;
  assign w_e_im      = bus.inc_min   & ~r_prev_im;
  assign w_e_ih      = bus.inc_hour  & ~r_prev_ih;
  assign w_match     = (bus.time_bcd == r_alarm);
  assign w_ring_done = (r_ring_cnt == RING_LAST);

  Bcd_Time_Inc u_work_inc (
    .i_bcd      (r_work),
    .i_inc_min  (w_e_im),
    .i_inc_hour (w_e_ih),
    .o_bcd      (w_work_inc)
  );

  Bcd_Time_Inc u_alarm_inc (
    .i_bcd      (r_alarm),
    .i_inc_min  (w_e_im),
    .i_inc_hour (w_e_ih),
    .o_bcd      (w_alarm_inc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_load_now  = 1'b0;
    w_copy_work = 1'b0;
    w_trigger   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_e_sc) begin
          w_next      = ST_SET_TIME;
          w_copy_work = 1'b1;
        end else if (w_e_sa) begin
          w_next = ST_SET_ALARM;
        end else if (w_match && r_armed) begin
          w_next    = ST_RINGING;
          w_trigger = 1'b1;
        end
      end
      ST_SET_TIME: begin
        if (w_e_sc) begin
          w_next     = ST_RUN;
          w_load_now = 1'b1;
        end
      end
      ST_SET_ALARM: begin
        if (w_e_sa) w_next = ST_RUN;
      end
      ST_RINGING: begin
        if (w_e_sc) begin
          w_next      = ST_SET_TIME;
          w_copy_work = 1'b1;
        end else if (w_e_sa) begin
          w_next = ST_SET_ALARM;
        end else if (w_e_off) begin
          w_next = ST_RUN;
`ifdef SNOOZE_EN
        end else if (w_e_im) begin
          w_next = ST_SNOOZE;
`endif
        end else if (bus.tick && w_ring_done) begin
          w_next = ST_RUN;
        end
      end
`ifdef SNOOZE_EN
      ST_SNOOZE: begin
        if (w_e_sc) begin
          w_next      = ST_SET_TIME;
          w_copy_work = 1'b1;
        end else if (w_e_sa) begin
          w_next = ST_SET_ALARM;
        end else if (w_e_off) begin
          w_next = ST_RUN;
        end else if (bus.tick && w_snz_done) begin
          w_next = ST_RINGING;
        end
      end
`endif
      default: w_next = ST_RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state;
  // run_enable stays low through the load cycle and rises the clk after.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_sc   <= 1'b0;
      r_prev_sa   <= 1'b0;
      r_prev_off  <= 1'b0;
      r_prev_im   <= 1'b0;
      r_prev_ih   <= 1'b0;
      r_work      <= '0;
      r_alarm     <= ALARM_RESET_BCD;
      r_load      <= 1'b0;
      r_load_bcd  <= '0;
      r_show      <= 1'b0;
      r_run_en    <= 1'b1;
      r_alarm_out <= 1'b0;
      r_armed     <= 1'b1;
      r_ring_cnt  <= '0;
    end else begin
      r_prev_sc   <= bus.set_clock;
      r_prev_sa   <= bus.set_alarm;
      r_prev_off  <= bus.alarm_off;
      r_prev_im   <= bus.inc_min;
      r_prev_ih   <= bus.inc_hour;
      if (w_copy_work)                r_work <= bus.time_bcd;
      else if (r_state == ST_SET_TIME) r_work <= w_work_inc;
      if (r_state == ST_SET_ALARM)    r_alarm <= w_alarm_inc;
      r_load      <= w_load_now;
      if (w_load_now) r_load_bcd <= r_work;
      r_show      <= (w_next == ST_SET_ALARM);
      r_run_en    <= (w_next != ST_SET_TIME) && !w_load_now;
      r_alarm_out <= (w_next == ST_RINGING);
      if (w_trigger)     r_armed <= 1'b0;
      else if (!w_match) r_armed <= 1'b1;
      if (r_state == ST_RINGING && w_next == ST_RINGING) begin
        if (bus.tick) r_ring_cnt <= r_ring_cnt + 8'd1;
      end else begin
        r_ring_cnt <= '0;
      end
    end
  end

`ifdef SNOOZE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_snz_cnt <= '0;
    end else if (r_state == ST_SNOOZE && w_next == ST_SNOOZE) begin
      if (bus.tick) r_snz_cnt <= r_snz_cnt + 10'd1;
    end else begin
      r_snz_cnt <= '0;
    end
  end
`endif

  assign bus.load       = r_load;
  assign bus.load_bcd   = r_load_bcd;
  assign bus.alarm_bcd  = r_alarm;
  assign bus.show_alarm = r_show;
  assign bus.run_enable = r_run_en;
  assign bus.alarm_out  = r_alarm_out;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed scenarios plus random
// button/tick/time traffic against a minutes-of-day behavioural model.
module tb_alarm_controller;

  localparam int unsigned RING_S = 60;
  localparam int unsigned SNZ_M  = 5;
`ifdef SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  typedef enum {M_RUN, M_SET_TIME, M_SET_ALARM, M_RING, M_SNOOZE} mode_t;

  logic clk = 1'b0;
  logic rst_n;
  alarm_controller_if bus();

  alarm_controller #(.RING_SECONDS(RING_S), .SNOOZE_MINUTES(SNZ_M)) u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model state: times are minutes of the day (0..1439)
  mode_t       m_mode;
  int          m_work, m_alarm, m_ring_n, m_snz_n, t_now;
  bit          m_armed, m_load;
  logic [15:0] m_load_val;
  bit          p_sc, p_sa, p_off, p_im, p_ih;

  function automatic logic [15:0] to_bcd(int mod);
    logic [3:0] ht, hu, mt, mu;
    ht = 4'((mod / 60) / 10);
    hu = 4'((mod / 60) % 10);
    mt = 4'((mod % 60) / 10);
    mu = 4'((mod % 60) % 10);
    return {ht, hu, mt, mu};
  endfunction

  function automatic int apply_inc(int mod, bit im, bit ih);
    int r = mod;
    if (im) r = (r / 60) * 60 + ((r % 60) + 1) % 60;
    if (ih) r = (((r / 60) + 1) % 24) * 60 + (r % 60);
    return r;
  endfunction

  task automatic pin(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_work = 0; m_alarm = 6 * 60; m_armed = 1'b1;
    m_ring_n = 0; m_snz_n = 0; m_load = 1'b0; m_load_val = '0;
    p_sc = 0; p_sa = 0; p_off = 0; p_im = 0; p_ih = 0;
  endtask

  task automatic model_step();
    bit esc, esa, eoff, eim, eih, match, ld;
    mode_t nm;
    esc  = bus.set_clock && !p_sc;
    esa  = bus.set_alarm && !p_sa;
    eoff = bus.alarm_off && !p_off;
    eim  = bus.inc_min   && !p_im;
    eih  = bus.inc_hour  && !p_ih;
    match = (t_now == m_alarm);
    nm = m_mode;
    ld = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (esc) begin nm = M_SET_TIME; m_work = t_now; end
        else if (esa) nm = M_SET_ALARM;
        else if (match && m_armed) begin nm = M_RING; m_armed = 1'b0; m_ring_n = 0; end
      end
      M_SET_TIME: begin
        if (esc) begin ld = 1'b1; m_load_val = to_bcd(m_work); nm = M_RUN; end
        m_work = apply_inc(m_work, eim, eih);
      end
      M_SET_ALARM: begin
        m_alarm = apply_inc(m_alarm, eim, eih);
        if (esa) nm = M_RUN;
      end
      M_RING: begin
        if (esc) begin nm = M_SET_TIME; m_work = t_now; end
        else if (esa) nm = M_SET_ALARM;
        else if (eoff) nm = M_RUN;
        else if (SNZ_ON && eim) begin nm = M_SNOOZE; m_snz_n = 0; end
        else if (bus.tick) begin
          m_ring_n++;
          if (m_ring_n == int'(RING_S)) nm = M_RUN;
        end
      end
      default: begin
        if (esc) begin nm = M_SET_TIME; m_work = t_now; end
        else if (esa) nm = M_SET_ALARM;
        else if (eoff) nm = M_RUN;
        else if (bus.tick) begin
          m_snz_n++;
          if (m_snz_n == int'(SNZ_M * 60)) begin nm = M_RING; m_ring_n = 0; end
        end
      end
    endcase
    if (!match) m_armed = 1'b1;
    m_load = ld;
    m_mode = nm;
    p_sc = bus.set_clock; p_sa = bus.set_alarm; p_off = bus.alarm_off;
    p_im = bus.inc_min;   p_ih = bus.inc_hour;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    else       model_reset();
    #1;
  endtask

  task automatic set_time(int mod);
    t_now = mod;
    bus.time_bcd = to_bcd(mod);
  endtask

  task automatic press(int id);
    case (id)
      0: bus.set_clock = 1'b1;
      1: bus.set_alarm = 1'b1;
      2: bus.alarm_off = 1'b1;
      3: bus.inc_min   = 1'b1;
      default: bus.inc_hour = 1'b1;
    endcase
    cycle();
    bus.set_clock = 1'b0; bus.set_alarm = 1'b0; bus.alarm_off = 1'b0;
    bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
    cycle();
  endtask

  task automatic tick_pulse();
    bus.tick = 1'b1;
    cycle();
    bus.tick = 1'b0;
    cycle();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      pin("load",       16'(bus.load),       16'(m_load));
      pin("load_bcd",   bus.load_bcd,        m_load_val);
      pin("alarm_bcd",  bus.alarm_bcd,       to_bcd(m_alarm));
      pin("show_alarm", 16'(bus.show_alarm), 16'(m_mode == M_SET_ALARM));
      pin("run_enable", 16'(bus.run_enable), 16'(m_mode != M_SET_TIME && !m_load));
      pin("alarm_out",  16'(bus.alarm_out),  16'(m_mode == M_RING));
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.tick = 0; bus.set_clock = 0; bus.set_alarm = 0; bus.alarm_off = 0;
    bus.inc_min = 0; bus.inc_hour = 0;
    set_time(0);
    model_reset();
    cycle();
    cycle();
    chk_en = 1'b1;
    pin("rst_alarm_bcd",  bus.alarm_bcd, 16'h0600);
    pin("rst_run_enable", 16'(bus.run_enable), 16'd1);
    pin("rst_load",       16'(bus.load), 16'd0);
    rst_n = 1'b1;

    // Alarm match rings the clk after time reaches 06:00, stops after 60 ticks
    set_time(5 * 60 + 59);
    cycle();
    pin("pre_match_quiet", 16'(bus.alarm_out), 16'd0);
    set_time(6 * 60);
    cycle();
    pin("match_rings", 16'(bus.alarm_out), 16'd1);
    for (int i = 0; i < 59; i++) tick_pulse();
    pin("ring_59_ticks", 16'(bus.alarm_out), 16'd1);
    tick_pulse();
    pin("ring_timeout", 16'(bus.alarm_out), 16'd0);
    repeat (5) cycle();
    pin("no_retrigger_same_min", 16'(bus.alarm_out), 16'd0);

    // Set time from 23:58: +3 min, +2 h -> 01:01
    set_time(23 * 60 + 58);
    cycle();
    bus.set_clock = 1'b1;
    cycle();
    pin("set_time_run_en", 16'(bus.run_enable), 16'd0);
    bus.set_clock = 1'b0;
    cycle();
    repeat (3) press(3);
    repeat (2) press(4);
    bus.set_clock = 1'b1;
    cycle();
    pin("load_pulse", 16'(bus.load), 16'd1);
    pin("load_value", bus.load_bcd, 16'h0101);
    bus.set_clock = 1'b0;
    cycle();
    pin("load_one_clk", 16'(bus.load), 16'd0);
    pin("run_en_after_load", 16'(bus.run_enable), 16'd1);

    // Simultaneous set_clock/set_alarm edges: set_clock wins
    bus.set_clock = 1'b1; bus.set_alarm = 1'b1;
    cycle();
    pin("both_show_alarm", 16'(bus.show_alarm), 16'd0);
    pin("both_run_en", 16'(bus.run_enable), 16'd0);
    bus.set_clock = 1'b0; bus.set_alarm = 1'b0;
    cycle();
    press(0);

    // alarm_off at tick 10 silences, no retrigger during 06:00
    set_time(5 * 60 + 59);
    cycle();
    set_time(6 * 60);
    cycle();
    pin("ring_again", 16'(bus.alarm_out), 16'd1);
    for (int i = 0; i < 9; i++) tick_pulse();
    bus.tick = 1'b1; bus.alarm_off = 1'b1;
    cycle();
    pin("alarm_off_silence", 16'(bus.alarm_out), 16'd0);
    bus.tick = 1'b0; bus.alarm_off = 1'b0;
    repeat (20) cycle();
    pin("off_no_retrigger", 16'(bus.alarm_out), 16'd0);

    // Edit alarm to 07:00, then reset in the middle of SET_TIME
    press(1);
    press(4);
    press(1);
    pin("alarm_edit", bus.alarm_bcd, 16'h0700);
    press(0);
    press(3);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    pin("mid_reset_alarm", bus.alarm_bcd, 16'h0600);
    pin("mid_reset_run_en", 16'(bus.run_enable), 16'd1);
    pin("mid_reset_load", 16'(bus.load), 16'd0);
    cycle();
    rst_n = 1'b1;
    cycle();
    press(2);

`ifdef SNOOZE_EN
    set_time(5 * 60 + 59);
    cycle();
    set_time(6 * 60);
    cycle();
    pin("snooze_pre_ring", 16'(bus.alarm_out), 16'd1);
    press(3);
    pin("snooze_quiet", 16'(bus.alarm_out), 16'd0);
    for (int i = 0; i < 299; i++) tick_pulse();
    pin("snooze_299", 16'(bus.alarm_out), 16'd0);
    tick_pulse();
    pin("snooze_reringing", 16'(bus.alarm_out), 16'd1);
    press(2);
`endif

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      bus.tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 11) == 0) bus.set_clock = ~bus.set_clock;
      if ($urandom_range(0, 11) == 0) bus.set_alarm = ~bus.set_alarm;
      if ($urandom_range(0, 9) == 0)  bus.alarm_off = ~bus.alarm_off;
      if ($urandom_range(0, 5) == 0)  bus.inc_min   = ~bus.inc_min;
      if ($urandom_range(0, 5) == 0)  bus.inc_hour  = ~bus.inc_hour;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 2))
          0: set_time(m_alarm);
          1: set_time((m_alarm + 1439) % 1440);
          default: set_time(int'($urandom_range(0, 1439)));
        endcase
      end
      if ($urandom_range(0, 1499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 SHALL have parameter RING_SECONDS, default 60, giving the seconds the alarm rings before auto-silence (range 1..255).
REQ-002 SHALL have parameter SNOOZE_MINUTES, default 5, giving the snooze delay in minutes (range 1..9).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic SHALL be on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tick, input, 1 bit: one-clk pulse once per second from the seconds chain.
REQ-006 SHALL have ports set_clock, set_alarm, alarm_off, inc_min, inc_hour, all inputs, 1 bit each: synchronous level buttons.
REQ-007 SHALL have port time_bcd, input, 16 bits: current time as {h_t,h_u,m_t,m_u} BCD.
REQ-008 SHALL have ports load (output, 1 bit, one-clk strobe) and load_bcd (output, 16 bits, value for the time counters).
REQ-009 SHALL have ports alarm_bcd (output, 16 bits, stored alarm time), show_alarm (output, 1 bit, display alarm_bcd instead of time), run_enable (output, 1 bit, count enable for the time chain) and alarm_out (output, 1 bit, buzzer).

Function
REQ-010 SHALL implement FSM states RUN, SET_TIME, SET_ALARM and RINGING, plus SNOOZE when enabled per REQ-024.
REQ-011 SHALL act only on rising edges of the button inputs, detected one clk after the input rises.
REQ-012 SHALL, from RUN, enter SET_TIME on a set_clock edge and SET_ALARM on a set_alarm edge; set_clock SHALL win when both occur in the same clk.
REQ-013 SHALL copy time_bcd into a working register on entry to SET_TIME, hold run_enable=0 while in SET_TIME, and edit only the working register.
REQ-014 SHALL, on a second set_clock edge in SET_TIME, pulse load=1 for exactly one clk with load_bcd equal to the working register, then return to RUN with run_enable=1 on the next clk.
REQ-015 SHALL, in SET_ALARM, drive show_alarm=1, edit alarm_bcd directly, and return to RUN on a set_alarm edge.
REQ-016 SHALL make an inc_min edge add one minute modulo 60 in BCD (m_u 9->0 carries into m_t; 59->00 with no hour carry).
REQ-017 SHALL make an inc_hour edge add one hour modulo 24 in BCD (09->10, 23->00); simultaneous inc_min and inc_hour edges SHALL both apply.
REQ-018 SHALL, in RUN, enter RINGING on the clk where time_bcd==alarm_bcd and the armed flag is 1, and SHALL then clear armed.
REQ-019 SHALL set armed again only when time_bcd!=alarm_bcd, so that each match triggers at most once per minute.
REQ-020 SHALL, in RINGING, drive alarm_out=1, count ticks, and return to RUN on an alarm_off edge or after RING_SECONDS ticks, whichever comes first.
REQ-021 SHALL, on a set_clock or set_alarm edge during RINGING, silence the alarm and go to the corresponding set state, with set_clock priority as in REQ-012.
REQ-022 SHALL keep alarm_out=0 in every state except RINGING.

Reset
REQ-023 SHALL, while reset=0, force state=RUN, alarm_bcd=16'h0600, working register=0, load=0, load_bcd=0, show_alarm=0, run_enable=1, alarm_out=0, armed=1, all counters=0 and all edge-detect registers=0; a reset during any state SHALL abort that state with no load pulse.

Configuration
REQ-024 SHALL, when SNOOZE_EN is defined, make an inc_min edge in RINGING enter SNOOZE (alarm_out=0), which re-enters RINGING after SNOOZE_MINUTES*60 ticks; an alarm_off edge or a set_clock/set_alarm edge in SNOOZE SHALL exit as in REQ-020/REQ-021. When SNOOZE_EN is not defined, the SNOOZE state and its counter SHALL be absent and inc_min SHALL be ignored in RINGING.

Structure
REQ-025 SHALL take the state enumeration, the BCD limit constants (9, 5, 2, 3) and the reset alarm value from a shared package, alarm_pkg.
REQ-026 SHALL implement the BCD minute/hour increment as one sub-module, Bcd_Time_Inc, used for both the working register and alarm_bcd.

Verification
REQ-027 SHALL cover: reset, then time_bcd=16'h0559 changing to 16'h0600 -> alarm_out=1 on the following clk; alarm_out=0 after 60 ticks.
REQ-028 SHALL cover: set_clock, three inc_min, two inc_hour, set_clock from time 16'h2358 -> one-clk load with load_bcd=16'h0101, and run_enable=0 throughout SET_TIME.
REQ-029 SHALL cover: set_clock and set_alarm edges in the same clk -> SET_TIME entered and show_alarm=0.
REQ-030 SHALL cover: RINGING with an alarm_off edge at tick 10 -> alarm_out=0 next clk, and no retrigger while time_bcd stays 16'h0600.
REQ-031 SHALL cover: reset asserted mid SET_TIME -> state RUN, load never pulses, alarm_bcd=16'h0600.
REQ-032 SHALL cover, with SNOOZE_EN: inc_min edge while ringing -> alarm_out=0 for 300 ticks, then alarm_out=1.
